top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter DIV, default 13500000, prescaler terminal count in clock cycles per LED count step; legal range 1..16777216.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 led  output  6  LED drive pattern derived from the 6-bit count.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.

Function
REQ-006 The block SHALL hold a 24-bit prescaler register, `pre`, and a 6-bit count register, `cnt`.
REQ-007 Each rising clk edge with rst=0: if pre == DIV-1, pre SHALL load 0 and assert a one-cycle internal tick; otherwise pre SHALL increment by 1.
REQ-008 On a tick cycle, cnt SHALL increment by 1 modulo 64, so 63 wraps to 0 with no stall or flag.
REQ-009 For DIV=1, pre SHALL stay 0 and cnt SHALL increment on every clock edge.
REQ-010 The step period SHALL be exactly DIV clocks, so cnt changes at edges DIV, 2*DIV, ... after reset release.
REQ-011 led SHALL be a pure combinational function of cnt only, adding zero latency.
REQ-012 No other output or state SHALL exist, and the block SHALL have no enable or load input.
REQ-013 Arithmetic SHALL be unsigned, and overflow SHALL be discarded by truncation.

Reset
REQ-014 With rst=1 at a rising edge, pre and cnt SHALL be 0 after that edge, regardless of tick.
REQ-015 Reset SHALL take priority over a coincident tick.
REQ-016 Reset asserted mid-count SHALL discard the partial prescale; counting restarts a full DIV period after release.
REQ-017 Before the first reset edge, register contents are undefined, and no power-on value is required.
REQ-018 The led value after reset SHALL be 6'h3F with LED_ACTIVE_LOW_EN defined and 6'h00 without it.

Configuration
REQ-019 The macro LED_ACTIVE_LOW_EN SHALL select LED polarity.
REQ-020 With LED_ACTIVE_LOW_EN defined, led SHALL equal ~cnt, for active-low board LEDs.
REQ-021 Without LED_ACTIVE_LOW_EN, led SHALL equal cnt.
REQ-022 LED_ACTIVE_LOW_EN SHALL NOT affect counting, timing or reset values of pre and cnt.

Verification
REQ-023 DIV=1, macro undefined: rst high 2 cycles, then low for 10 cycles -> led reads 0,1,2,...,10 after successive edges.
REQ-024 DIV=4, macro undefined: release reset, run 12 cycles -> led steps 0->1 at edge 4, 1->2 at edge 8, 2->3 at edge 12.
REQ-025 DIV=1, macro undefined: run 64 cycles from reset -> led reaches 63, then 0 on the next edge (wrap).
REQ-026 DIV=4: assert rst on a tick edge when cnt=5 -> cnt=0 and pre=0 after that edge, and the next step occurs 4 edges after release.
REQ-027 DIV=1, LED_ACTIVE_LOW_EN defined: reset -> led=6'h3F; after 1 edge led=6'h3E; after 63 edges led=6'h00.
REQ-028 DIV=3: hold rst high for 10 cycles -> led stays at its reset value throughout.

Source files
------------

// File: rtl/top.sv
// LED counter: a 24-bit prescaler divides clk by DIV and steps a 6-bit count
// that drives the LEDs. Define LED_ACTIVE_LOW_EN for active-low board LEDs.
module top #(
  parameter int unsigned DIV = 32'd13500000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] led
);

  localparam int unsigned PRE_W = 24;
  localparam int unsigned CNT_W = 6;
  localparam logic [PRE_W-1:0] TERM = PRE_W'(DIV - 32'd1);

  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (pre == TERM);

  // Reset wins over a coincident tick and discards any partial prescale.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      cnt <= '0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + CNT_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~cnt;
`else
  assign led = cnt;
`endif

endmodule

// File: tb/tb_top.sv
// Bench for top: three instances (DIV=1,4,3) with per-test expected-value queues.
module tb_top;

  logic       clk = 1'b0;
  logic       rst1, rst4, rst3;
  logic [5:0] led1, led4, led3;
  logic [5:0] q1[$];
  logic [5:0] q4[$];
  logic [5:0] q3[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  top #(.DIV(1)) dut1 (.clk(clk), .rst(rst1), .led(led1));
  top #(.DIV(4)) dut4 (.clk(clk), .rst(rst4), .led(led4));
  top #(.DIV(3)) dut3 (.clk(clk), .rst(rst3), .led(led3));

  function automatic logic [5:0] pol(input logic [5:0] c);
`ifdef LED_ACTIVE_LOW_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  task automatic test_reset();
    logic [5:0] e;
    for (int k = 0; k < 2; k++) begin
      rst1 = 1'b1; rst4 = 1'b1; rst3 = 1'b1;
      q1.push_back(pol(6'd0)); q4.push_back(pol(6'd0)); q3.push_back(pol(6'd0));
      @(posedge clk); #1;
      e = q1.pop_front(); compared++;
      if (led1 !== e) begin mismatched++; $display("FAIL reset dut1 cyc=%0d led=%h expected=%h", k, led1, e); end
      e = q4.pop_front(); compared++;
      if (led4 !== e) begin mismatched++; $display("FAIL reset dut4 cyc=%0d led=%h expected=%h", k, led4, e); end
      e = q3.pop_front(); compared++;
      if (led3 !== e) begin mismatched++; $display("FAIL reset dut3 cyc=%0d led=%h expected=%h", k, led3, e); end
    end
  endtask

  // DIV=1: one step per edge after release, wrapping 63 -> 0.
  task automatic test_div1_count(input int n, input string name);
    logic [5:0] e;
    rst1 = 1'b1;
    q1.push_back(pol(6'd0));
    @(posedge clk); #1;
    e = q1.pop_front(); compared++;
    if (led1 !== e) begin mismatched++; $display("FAIL %s reset led=%h expected=%h", name, led1, e); end
    rst1 = 1'b0;
    for (int k = 1; k <= n; k++) begin
      q1.push_back(pol(6'(k % 64)));
      @(posedge clk); #1;
      e = q1.pop_front(); compared++;
      if (led1 !== e) begin mismatched++; $display("FAIL %s edge=%0d led=%h expected=%h", name, k, led1, e); end
    end
  endtask

  task automatic test_div4_steps();
    logic [5:0] e;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      q4.push_back(pol(6'(k / 4)));
      @(posedge clk); #1;
      e = q4.pop_front(); compared++;
      if (led4 !== e) begin mismatched++; $display("FAIL div4_steps edge=%0d led=%h expected=%h", k, led4, e); end
    end
  endtask

  // Reset lands on the tick edge that would move cnt 5 -> 6.
  task automatic test_reset_on_tick();
    logic [5:0] e;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      q4.push_back(pol(6'(k / 4)));
      @(posedge clk); #1;
      e = q4.pop_front(); compared++;
      if (led4 !== e) begin mismatched++; $display("FAIL tick_rst run edge=%0d led=%h expected=%h", k, led4, e); end
    end
    rst4 = 1'b1;
    q4.push_back(pol(6'd0));
    @(posedge clk); #1;
    e = q4.pop_front(); compared++;
    if (led4 !== e) begin mismatched++; $display("FAIL tick_rst led=%h expected=%h", led4, e); end
    compared++;
    if (dut4.pre !== 24'd0) begin mismatched++; $display("FAIL tick_rst pre=%h expected=000000", dut4.pre); end
    rst4 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      q4.push_back(pol(6'(k / 4)));
      @(posedge clk); #1;
      e = q4.pop_front(); compared++;
      if (led4 !== e) begin mismatched++; $display("FAIL tick_rst after edge=%0d led=%h expected=%h", k, led4, e); end
    end
  endtask

  // Reset two edges into a prescale period; the partial count must be dropped.
  task automatic test_mid_reset();
    logic [5:0] e;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      q4.push_back(pol((k == 4) ? 6'd1 : 6'd0));
      @(posedge clk); #1;
      e = q4.pop_front(); compared++;
      if (led4 !== e) begin mismatched++; $display("FAIL mid_reset edge=%0d led=%h expected=%h", k, led4, e); end
    end
  endtask

  task automatic test_hold_reset();
    logic [5:0] e;
    for (int k = 0; k < 10; k++) begin
      rst3 = 1'b1;
      q3.push_back(pol(6'd0));
      @(posedge clk); #1;
      e = q3.pop_front(); compared++;
      if (led3 !== e) begin mismatched++; $display("FAIL hold_reset cyc=%0d led=%h expected=%h", k, led3, e); end
    end
    rst3 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      q3.push_back(pol(6'(k / 3)));
      @(posedge clk); #1;
      e = q3.pop_front(); compared++;
      if (led3 !== e) begin mismatched++; $display("FAIL div3_run edge=%0d led=%h expected=%h", k, led3, e); end
    end
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; rst3 = 1'b1;
    test_reset();
    test_div1_count(10, "div1_count");
    test_div4_steps();
    test_div1_count(66, "div1_wrap");
    test_reset_on_tick();
    test_mid_reset();
    test_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
